// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM execute-stage types and constants
// Purpose : ALU opcode enum, NZCV bit positions and the EX/MEM register layout.
// Ports   : none (package).
package arm_pkg;

   localparam int ARM_DW = 32;

   typedef enum logic [3:0] {
      EXE_NOP = 4'b0000,
      EXE_MOV = 4'b0001,
      EXE_ADD = 4'b0010,
      EXE_ADC = 4'b0011,
      EXE_SUB = 4'b0100,
      EXE_SBC = 4'b0101,
      EXE_AND = 4'b0110,
      EXE_ORR = 4'b0111,
      EXE_EOR = 4'b1000,
      EXE_MVN = 4'b1001,
      EXE_MUL = 4'b1010
   } exe_cmd_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic [3:0]        dest;
      logic [ARM_DW-1:0] res;
      logic [ARM_DW-1:0] rm;
   } exe_mem_t;

endpackage

// File: rtl/arm_alu.sv
// rtl/arm_alu.sv - combinational ARM ALU with NZCV generation
// Purpose : computes the data-processing result and the next NZCV value.
// Ports   : i_val1, i_val2 (DW) operands; i_cmd (4) opcode; i_nzcv (4) current flags
//           (C is the carry-in); o_res (DW) result; o_nzcv (4) next flags.
module arm_alu
   import arm_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] i_val1,
   input  logic [DW-1:0] i_val2,
   input  logic [3:0]    i_cmd,
   input  logic [3:0]    i_nzcv,
   output logic [DW-1:0] o_res,
   output logic [3:0]    o_nzcv
);

   logic [DW:0] w_sum;
   logic        w_arith;
   logic        w_logic;
   logic        w_sub;
   logic        w_c_in;

   assign w_c_in = i_nzcv[FLAG_C];

   always_comb begin
      w_sum   = '0;
      w_arith = 1'b0;
      w_logic = 1'b0;
      w_sub   = 1'b0;
      o_res   = '0;
      o_nzcv  = i_nzcv;
      case (i_cmd)
         EXE_MOV: begin o_res = i_val2;          w_logic = 1'b1; end
         EXE_MVN: begin o_res = ~i_val2;         w_logic = 1'b1; end
         EXE_AND: begin o_res = i_val1 & i_val2; w_logic = 1'b1; end
         EXE_ORR: begin o_res = i_val1 | i_val2; w_logic = 1'b1; end
         EXE_EOR: begin o_res = i_val1 ^ i_val2; w_logic = 1'b1; end
         EXE_ADD: begin
            w_sum   = {1'b0, i_val1} + {1'b0, i_val2};
            w_arith = 1'b1;
         end
         EXE_ADC: begin
            w_sum   = {1'b0, i_val1} + {1'b0, i_val2} + (DW+1)'(w_c_in);
            w_arith = 1'b1;
         end
         // Subtraction as a + ~b + 1 so the carry-out is the ARM not-borrow.
         EXE_SUB: begin
            w_sum   = {1'b0, i_val1} + {1'b0, ~i_val2} + (DW+1)'(1'b1);
            w_arith = 1'b1;
            w_sub   = 1'b1;
         end
         EXE_SBC: begin
            w_sum   = {1'b0, i_val1} + {1'b0, ~i_val2} + (DW+1)'(w_c_in);
            w_arith = 1'b1;
            w_sub   = 1'b1;
         end
         default: ;
      endcase

      if (w_arith) begin
         o_res          = w_sum[DW-1:0];
         o_nzcv[FLAG_C] = w_sum[DW];
         // Overflow: operands' signs agree (add) or differ (sub) and the result sign flips.
         o_nzcv[FLAG_V] = ((i_val1[DW-1] ^ i_val2[DW-1]) == w_sub) &&
                          (o_res[DW-1] != i_val1[DW-1]);
      end
      if (w_arith || w_logic) begin
         o_nzcv[FLAG_N] = o_res[DW-1];
         o_nzcv[FLAG_Z] = (o_res == '0);
      end
   end

endmodule

// File: rtl/exe_alu_stage.sv
// rtl/exe_alu_stage.sv - ARM execute stage: ALU, NZCV register, EX/MEM register
// Purpose : combines Val1 with Val2 in arm_alu, keeps the status register and
//           registers result and controls into EX/MEM, honouring freeze/flush.
//           Optional iterative multiplier enabled by defining MUL_ITER_EN.
// Ports   : clk, rst (sync, active-high); freeze, flush; in_valid; val1, val2,
//           val_rm_in (DW); exe_cmd (4); s_in, wb_en_in, mem_r_en_in, mem_w_en_in;
//           dest_in (4); status_q (4) {N,Z,C,V}; alu_res_out, val_rm_out (DW);
//           wb_en_out, mem_r_en_out, mem_w_en_out, dest_out (4), valid_out; busy_out.
module exe_alu_stage
   import arm_pkg::*;
#(
   parameter int DW        = ARM_DW,
   parameter int MUL_STEPS = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [DW-1:0] val1,
   input  logic [DW-1:0] val2,
   input  logic [3:0]    exe_cmd,
   input  logic          s_in,
   input  logic          wb_en_in,
   input  logic          mem_r_en_in,
   input  logic          mem_w_en_in,
   input  logic [3:0]    dest_in,
   input  logic [DW-1:0] val_rm_in,
   output logic [3:0]    status_q,
   output logic [DW-1:0] alu_res_out,
   output logic          wb_en_out,
   output logic          mem_r_en_out,
   output logic          mem_w_en_out,
   output logic [3:0]    dest_out,
   output logic [DW-1:0] val_rm_out,
   output logic          valid_out,
   output logic          busy_out
);

   logic [DW-1:0] w_alu_res;
   logic [3:0]    w_alu_nzcv;
   logic          w_accept;
   logic          w_is_mul;
   logic          w_mul_done;
   logic          w_mul_s;
   exe_mem_t      w_mul_exmem;

   exe_mem_t      r_exmem;
   logic          r_valid;
   logic [3:0]    r_status;

   arm_alu #(.DW(DW)) u_alu (
      .i_val1 (val1),
      .i_val2 (val2),
      .i_cmd  (exe_cmd),
      .i_nzcv (r_status),
      .o_res  (w_alu_res),
      .o_nzcv (w_alu_nzcv)
   );

   assign w_accept = in_valid & ~freeze & ~flush & ~busy_out;

`ifdef MUL_ITER_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mul_state_e;
   localparam int STEP_W = $clog2(MUL_STEPS + 1);

   mul_state_e    r_state;
   logic          r_busy;
   logic [DW-1:0] r_acc;
   logic [DW-1:0] r_mcand;
   logic [DW-1:0] r_mplier;
   logic [STEP_W-1:0] r_step;
   exe_mem_t      r_mul_ctrl;
   logic          r_mul_s;

   assign w_is_mul   = (exe_cmd == EXE_MUL);
   assign w_mul_done = (r_state == ST_DONE) & ~freeze & ~flush;
   assign w_mul_s    = r_mul_s;
   assign busy_out   = r_busy;

   always_comb begin
      w_mul_exmem     = r_mul_ctrl;
      w_mul_exmem.res = r_acc;
   end

   // Shift-add over 8 multiplier bits per edge; only the low DW product bits are kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_step     <= '0;
         r_mul_ctrl <= '0;
         r_mul_s    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_state             <= ST_RUN;
                  r_busy              <= 1'b1;
                  r_acc               <= '0;
                  r_mcand             <= val1;
                  r_mplier            <= val2;
                  r_step              <= '0;
                  r_mul_s             <= s_in;
                  r_mul_ctrl.wb_en    <= wb_en_in;
                  r_mul_ctrl.mem_r_en <= mem_r_en_in;
                  r_mul_ctrl.mem_w_en <= mem_w_en_in;
                  r_mul_ctrl.dest     <= dest_in;
                  r_mul_ctrl.res      <= '0;
                  r_mul_ctrl.rm       <= val_rm_in;
               end
            end
            ST_RUN: begin
               if (flush) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc    <= r_acc + r_mcand * DW'(r_mplier[7:0]);
                  r_mcand  <= r_mcand << 8;
                  r_mplier <= r_mplier >> 8;
                  r_step   <= r_step + 1'b1;
                  if (r_step == STEP_W'(MUL_STEPS - 1))
                     r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (flush || !freeze) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
`else
   logic w_unused_mul_steps;
   assign w_unused_mul_steps = (MUL_STEPS > 0);
   assign w_is_mul    = 1'b0;
   assign w_mul_done  = 1'b0;
   assign w_mul_s     = 1'b0;
   assign w_mul_exmem = '0;
   assign busy_out    = 1'b0;
`endif

   // EX/MEM register. A multiply leaves a bubble on its accept edge and
   // writes its result when the FSM completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exmem <= '0;
         r_valid <= 1'b0;
      end else if (w_mul_done) begin
         r_exmem <= w_mul_exmem;
         r_valid <= 1'b1;
      end else if (w_accept && !w_is_mul) begin
         r_exmem.wb_en    <= wb_en_in;
         r_exmem.mem_r_en <= mem_r_en_in;
         r_exmem.mem_w_en <= mem_w_en_in;
         r_exmem.dest     <= dest_in;
         r_exmem.res      <= w_alu_res;
         r_exmem.rm       <= val_rm_in;
         r_valid          <= 1'b1;
      end else if (freeze && !flush) begin
         r_exmem <= r_exmem;
         r_valid <= r_valid;
      end else begin
         r_exmem.wb_en    <= 1'b0;
         r_exmem.mem_r_en <= 1'b0;
         r_exmem.mem_w_en <= 1'b0;
         r_valid          <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_status <= 4'b0000;
      end else if (w_accept && !w_is_mul && s_in) begin
         r_status <= w_alu_nzcv;
      end else if (w_mul_done && w_mul_s) begin
         r_status[FLAG_N] <= w_mul_exmem.res[DW-1];
         r_status[FLAG_Z] <= (w_mul_exmem.res == '0);
      end
   end

   assign status_q     = r_status;
   assign alu_res_out  = r_exmem.res;
   assign wb_en_out    = r_exmem.wb_en;
   assign mem_r_en_out = r_exmem.mem_r_en;
   assign mem_w_en_out = r_exmem.mem_w_en;
   assign dest_out     = r_exmem.dest;
   assign val_rm_out   = r_exmem.rm;
   assign valid_out    = r_valid;

endmodule

// File: tb/tb_exe_alu_stage.sv
// tb/tb_exe_alu_stage.sv - scoreboard bench for exe_alu_stage
module tb_exe_alu_stage;
   import arm_pkg::*;

   localparam int DW = 32;
   localparam int STEPS = 4;

   logic          clk = 1'b0;
   logic          rst, freeze, flush, in_valid;
   logic [DW-1:0] val1, val2, val_rm_in;
   logic [3:0]    exe_cmd, dest_in;
   logic          s_in, wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [3:0]    status_q, dest_out;
   logic [DW-1:0] alu_res_out, val_rm_out;
   logic          wb_en_out, mem_r_en_out, mem_w_en_out, valid_out, busy_out;

   exe_alu_stage #(.DW(DW), .MUL_STEPS(STEPS)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
      .val1(val1), .val2(val2), .exe_cmd(exe_cmd), .s_in(s_in),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .dest_in(dest_in), .val_rm_in(val_rm_in), .status_q(status_q),
      .alu_res_out(alu_res_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .mem_w_en_out(mem_w_en_out), .dest_out(dest_out), .val_rm_out(val_rm_out),
      .valid_out(valid_out), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  ctl;
      logic [3:0]  dest;
      logic [31:0] rm;
      logic [3:0]  st;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   logic m_hold = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a fresh EX/MEM load is any valid slot not produced by a held (frozen) edge.
   always @(posedge clk) m_hold = freeze && !flush && !rst;

   always @(negedge clk) begin
      if (valid_out === 1'b1 && !m_hold) begin
         if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_valid: got res %h expected no output", alu_res_out);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_res", alu_res_out, e.res);
            chk("sb_ctl", {wb_en_out, mem_r_en_out, mem_w_en_out}, e.ctl);
            chk("sb_dest_rm", {dest_out, val_rm_out[27:0]}, {e.dest, e.rm[27:0]});
            chk("sb_status", status_q, e.st);
         end
      end
   end

   task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                        input logic s, input logic wb, input logic mr, input logic mw,
                        input logic [3:0] dest, input logic [31:0] rm,
                        input logic push, input logic [31:0] eres, input logic [3:0] est);
      exe_cmd = cmd; val1 = v1; val2 = v2; s_in = s;
      wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw; dest_in = dest; val_rm_in = rm;
      in_valid = 1'b1;
      if (push) q.push_back('{eres, {wb, mr, mw}, dest, rm, est});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_res"}, alu_res_out, 32'h0);
      chk({tag, "_ctl"}, {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out}, 4'h0);
      chk({tag, "_dest_rm"}, {dest_out, val_rm_out[27:0]}, 32'h0);
      chk({tag, "_status"}, status_q, 4'h0);
      chk({tag, "_busy"}, busy_out, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
      val1 = '0; val2 = '0; val_rm_in = '0; exe_cmd = '0; dest_in = '0;
      s_in = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      //    cmd   val1          val2          S  wb mr mw dst rm            push exp_res       st
      issue(4'h2, 32'h7FFFFFFF, 32'h00000001, 1, 1, 0, 0, 1,  32'h0,        1,   32'h80000000, 4'b1001);
      issue(4'h4, 32'h5,        32'h3,        1, 1, 0, 0, 2,  32'h0,        1,   32'h2,        4'b0010);
      issue(4'h3, 32'h1,        32'h1,        1, 1, 0, 0, 3,  32'h0,        1,   32'h3,        4'b0000);
      issue(4'h5, 32'h5,        32'h3,        1, 1, 0, 0, 4,  32'h0,        1,   32'h1,        4'b0010);
      issue(4'h4, 32'h3,        32'h5,        1, 1, 0, 0, 5,  32'h0,        1,   32'hFFFFFFFE, 4'b1000);
      issue(4'h3, 32'hFFFFFFFF, 32'h1,        1, 1, 0, 0, 6,  32'h0,        1,   32'h0,        4'b0110);
      issue(4'h4, 32'h80000000, 32'h1,        1, 1, 0, 0, 7,  32'h0,        1,   32'h7FFFFFFF, 4'b0011);
      issue(4'h9, 32'h0,        32'h0,        1, 1, 0, 0, 8,  32'h0,        1,   32'hFFFFFFFF, 4'b1011);
      issue(4'h6, 32'hF0,       32'h0F,       1, 1, 0, 0, 9,  32'h0,        1,   32'h0,        4'b0111);
      issue(4'h7, 32'hF0,       32'h0F,       0, 1, 0, 0, 10, 32'h0,        1,   32'hFF,       4'b0111);
      issue(4'h8, 32'hFF,       32'h0F,       1, 1, 0, 0, 11, 32'h0,        1,   32'hF0,       4'b0011);
      issue(4'h1, 32'h0,        32'h12345678, 0, 1, 0, 0, 12, 32'h0,        1,   32'h12345678, 4'b0011);
      issue(4'hF, 32'h5,        32'h6,        1, 1, 0, 0, 13, 32'h0,        1,   32'h0,        4'b0011);
      issue(4'h2, 32'h100,      32'h4,        0, 0, 0, 1, 14, 32'hDEADBEEF, 1,   32'h104,      4'b0011);
      issue(4'h2, 32'h200,      32'h8,        0, 1, 1, 0, 15, 32'h0,        1,   32'h208,      4'b0011);

      // Freeze for 3 edges with an ADD waiting: the LDR slot must stay put.
      exe_cmd = 4'h2; val1 = 32'd10; val2 = 32'd20; s_in = 1'b1; wb_en_in = 1'b1;
      mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; dest_in = 4'd3; val_rm_in = 32'h0;
      in_valid = 1'b1; freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("freeze_res", alu_res_out, 32'h208);
         chk("freeze_ctl", {valid_out, wb_en_out, mem_r_en_out, dest_out}, {3'b111, 4'd15});
         chk("freeze_status", status_q, 4'b0011);
      end
      q.push_back('{32'd30, 3'b100, 4'd3, 32'h0, 4'b0000});
      freeze = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;

      // CMP with flush and freeze together: bubble, no flag update.
      exe_cmd = 4'h4; val1 = 32'd7; val2 = 32'd7; s_in = 1'b1; wb_en_in = 1'b0;
      in_valid = 1'b1; flush = 1'b1; freeze = 1'b1;
      @(posedge clk); #1;
      chk("flushfrz_valid", {valid_out, wb_en_out}, 2'b00);
      chk("flushfrz_status", status_q, 4'b0000);
      freeze = 1'b0;
      exe_cmd = 4'h2; wb_en_in = 1'b1; val1 = 32'hFFFFFFFF; val2 = 32'h1;
      @(posedge clk); #1;
      chk("flush_valid", {valid_out, wb_en_out}, 2'b00);
      chk("flush_status", status_q, 4'b0000);
      flush = 1'b0; in_valid = 1'b0;

      // Load a slot, then reset alongside a new ADD.
      issue(4'h4, 32'h1, 32'h2, 1, 1, 0, 0, 2, 32'h0, 1, 32'hFFFFFFFF, 4'b1000);
      rst = 1'b1;
      issue(4'h2, 32'h1, 32'h1, 1, 1, 0, 0, 5, 32'h55, 0, 32'h0, 4'h0);
      chk_all_zero("midrst");
      rst = 1'b0;
      issue(4'h2, 32'hFFFFFFFF, 32'h2, 1, 1, 0, 0, 6, 32'h0, 1, 32'h1, 4'b0010);
      @(posedge clk); #1;
      chk("idle_valid", valid_out, 1'b0);

`ifdef MUL_ITER_EN
      begin
         int busy_cnt;
         busy_cnt = 0;
         issue(4'hA, 32'h00010001, 32'h00010001, 1, 1, 0, 0, 7, 32'h0, 1, 32'h00020001, 4'b0010);
         for (int i = 0; i < 20; i++) begin
            if (busy_out) busy_cnt++;
            else if (busy_cnt > 0) break;
            @(posedge clk); #1;
         end
         chk("mul_busy_cycles", busy_cnt, STEPS + 1);
         @(posedge clk); #1;
         issue(4'hA, 32'h00010001, 32'h00010001, 1, 1, 0, 0, 8, 32'h0, 0, 32'h0, 4'h0);
         @(posedge clk); #1;
         flush = 1'b1;
         @(posedge clk); #1;
         flush = 1'b0;
         busy_cnt = 0;
         for (int i = 0; i < 10; i++) begin
            if (valid_out) busy_cnt++;
            @(posedge clk); #1;
         end
         chk("mul_flush_valid", busy_cnt, 0);
         chk("mul_flush_busy", busy_out, 1'b0);
         chk("mul_flush_status", status_q, 4'b0010);
      end
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
